// File: rtl/skolem_inv_sweep_checker.sv
// Exhaustive checker for a combinational Skolem function of "exists x: bvashr(x, s) <s t".
// Drives every (s, t) pair, scores the returned candidate, and brute-forces x on a miss.
module skolem_inv_sweep_checker #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   output logic [W-1:0]   cand_s,
   output logic [W-1:0]   cand_t,
   input  logic [W-1:0]   cand_x,
   output logic           busy,
   output logic           done,
   output logic [2*W:0]   pass_cnt,
   output logic [2*W:0]   vac_cnt,
   output logic [2*W:0]   fail_cnt,
   output logic           ff_valid,
   output logic [W-1:0]   ff_s,
   output logic [W-1:0]   ff_t,
   output logic [W-1:0]   ff_x
);

   localparam int KW = 2 * W;
   localparam int CW = 2 * W + 1;
   localparam logic [W-1:0]  W_S     = W[W-1:0];
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [KW-1:0] K_ONE   = {{(KW-1){1'b0}}, 1'b1};
   localparam logic [W-1:0]  XS_ONE  = {{(W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRIVE = 3'd1,
      CHECK = 3'd2,
      SWEEP = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t          state_r;
   logic [KW-1:0]   k_r;
   logic [W-1:0]    xs_r;
   logic [W-1:0]    x_r;
   logic            p_cand_s;
   logic            p_xs_s;
   logic            adv_s;

   // Shift amounts of W or more saturate at W, which leaves only sign bits in the low field.
   function automatic logic pred(input logic [W-1:0] x, input logic [W-1:0] s,
                                 input logic [W-1:0] t);
      logic [2*W-1:0] ext;
      logic [2*W-1:0] shifted;
      logic [W-1:0]   amt;
      logic [W-1:0]   r;
      ext = {{W{x[W-1]}}, x};
      if (s >= W_S) begin
         amt = W_S;
      end else begin
         amt = s;
      end
      shifted = ext >> amt;
      r = shifted[W-1:0];
      if (r[W-1] != t[W-1]) begin
         pred = r[W-1];
      end else begin
         pred = (r < t);
      end
   endfunction

   assign cand_s = k_r[W-1:0];
   assign cand_t = k_r[KW-1:W];

   // Predicate evaluation for the sampled candidate and the brute-force value, plus pair-advance.
   always_comb begin
      p_cand_s = pred(cand_x, k_r[W-1:0], k_r[KW-1:W]);
      p_xs_s   = pred(xs_r, k_r[W-1:0], k_r[KW-1:W]);
      adv_s    = 1'b0;
      case (state_r)
         CHECK:   adv_s = p_cand_s;
         SWEEP:   adv_s = p_xs_s | (&xs_r);
         default: adv_s = 1'b0;
      endcase
   end

   // Sweep FSM with counters and first-failure capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         k_r      <= '0;
         xs_r     <= '0;
         x_r      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass_cnt <= '0;
         vac_cnt  <= '0;
         fail_cnt <= '0;
         ff_valid <= 1'b0;
         ff_s     <= '0;
         ff_t     <= '0;
         ff_x     <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  pass_cnt <= '0;
                  vac_cnt  <= '0;
                  fail_cnt <= '0;
                  ff_valid <= 1'b0;
                  ff_s     <= '0;
                  ff_t     <= '0;
                  ff_x     <= '0;
                  done     <= 1'b0;
                  busy     <= 1'b1;
                  k_r      <= '0;
                  state_r  <= DRIVE;
               end
            end
            DRIVE: begin
               state_r <= CHECK;
            end
            CHECK: begin
               x_r  <= cand_x;
               xs_r <= '0;
               if (p_cand_s) begin
                  pass_cnt <= pass_cnt + CNT_ONE;
               end else begin
                  state_r <= SWEEP;
               end
            end
            SWEEP: begin
               if (p_xs_s) begin
                  fail_cnt <= fail_cnt + CNT_ONE;
                  if (!ff_valid) begin
                     ff_valid <= 1'b1;
                     ff_s     <= k_r[W-1:0];
                     ff_t     <= k_r[KW-1:W];
                     ff_x     <= x_r;
                  end
               end else if (&xs_r) begin
                  vac_cnt <= vac_cnt + CNT_ONE;
               end else begin
                  xs_r <= xs_r + XS_ONE;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
         // Pair finished: step to the next {t, s} or close the sweep.
         if (adv_s) begin
            if (&k_r) begin
               state_r <= DONE;
               busy    <= 1'b0;
               done    <= 1'b1;
            end else begin
               k_r     <= k_r + K_ONE;
               state_r <= DRIVE;
            end
         end
      end
   end

endmodule

// File: tb/tb_skolem_inv_sweep_checker.sv
// Directed bench for skolem_inv_sweep_checker: a behavioural sweep model fills a scoreboard
// at each start, and the entry is popped and compared when done rises.
module tb_skolem_inv_sweep_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] cand_s, cand_t, cand_x;
   logic       busy, done, ff_valid;
   logic [8:0] pass_cnt, vac_cnt, fail_cnt;
   logic [3:0] ff_s, ff_t, ff_x;

   int checks = 0;
   int failures = 0;
   int busy_total = 0;
   int busy_base = 0;
   logic [1:0] mode_r = 2'd0;

   typedef struct {
      int pass;
      int vac;
      int fail;
      int ffv;
      int ffs;
      int fft;
      int ffx;
      int cyc;
   } exp_t;

   exp_t sb_q[$];

   skolem_inv_sweep_checker #(.W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cand_s(cand_s), .cand_t(cand_t), .cand_x(cand_x),
      .busy(busy), .done(done),
      .pass_cnt(pass_cnt), .vac_cnt(vac_cnt), .fail_cnt(fail_cnt),
      .ff_valid(ff_valid), .ff_s(ff_s), .ff_t(ff_t), .ff_x(ff_x)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (busy) busy_total <= busy_total + 1;
   end

   function automatic logic tb_pred(input logic [3:0] x, input logic [3:0] s, input logic [3:0] t);
      logic signed [3:0] xv, tv, r;
      xv = x;
      tv = t;
      r = xv >>> s;
      return r < tv;
   endfunction

   function automatic logic [3:0] ref_x(input logic [3:0] s, input logic [3:0] t);
      logic [3:0] v;
      v = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (tb_pred(i[3:0], s, t)) v = i[3:0];
      end
      return v;
   endfunction

   function automatic logic [3:0] skolem(input logic [1:0] m, input logic [3:0] s, input logic [3:0] t);
      case (m)
         2'd0:    return 4'b1000;
         2'd1:    return 4'b0000;
         default: return ref_x(s, t);
      endcase
   endfunction

   always_comb begin
      cand_x = skolem(mode_r, cand_s, cand_t);
   end

   function automatic exp_t model(input logic [1:0] m);
      exp_t e;
      logic [7:0] kk;
      logic [3:0] x;
      int w;
      e = '{default: 0};
      for (int k = 0; k < 256; k++) begin
         kk = k[7:0];
         x = skolem(m, kk[3:0], kk[7:4]);
         if (tb_pred(x, kk[3:0], kk[7:4])) begin
            e.pass++;
            e.cyc += 2;
         end else begin
            w = -1;
            for (int j = 0; j < 16; j++) begin
               if (w < 0 && tb_pred(j[3:0], kk[3:0], kk[7:4])) w = j;
            end
            if (w >= 0) begin
               e.fail++;
               e.cyc += 3 + w;
               if (e.ffv == 0) begin
                  e.ffv = 1;
                  e.ffs = int'(kk[3:0]);
                  e.fft = int'(kk[7:4]);
                  e.ffx = int'(x);
               end
            end else begin
               e.vac++;
               e.cyc += 18;
            end
         end
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic start_run(input logic [1:0] m, input string tag);
      mode_r = m;
      sb_q.push_back(model(m));
      @(negedge clk);
      busy_base = busy_total;
      pulse_start();
      chk({tag, "_busy_after_start"}, busy, 1);
      chk({tag, "_done_cleared"}, done, 0);
      chk({tag, "_pass_cleared"}, pass_cnt, 0);
   endtask

   task automatic wait_k(input int target, input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 6000 && !found; i++) begin
         @(negedge clk);
         if ({cand_t, cand_s} == target[7:0] && busy) found = 1'b1;
      end
      chk({tag, "_reached"}, found, 1);
   endtask

   task automatic finish_run(input string tag);
      exp_t e;
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 6000 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk({tag, "_done_seen"}, seen, 1);
      e = sb_q.pop_front();
      chk({tag, "_pass_cnt"}, pass_cnt, e.pass);
      chk({tag, "_vac_cnt"}, vac_cnt, e.vac);
      chk({tag, "_fail_cnt"}, fail_cnt, e.fail);
      chk({tag, "_ff_valid"}, ff_valid, e.ffv);
      chk({tag, "_ff_s"}, ff_s, e.ffs);
      chk({tag, "_ff_t"}, ff_t, e.fft);
      chk({tag, "_ff_x"}, ff_x, e.ffx);
      chk({tag, "_busy_cycles"}, busy_total - busy_base, e.cyc);
      chk({tag, "_busy_low"}, busy, 0);
      chk({tag, "_sum"}, pass_cnt + vac_cnt + fail_cnt, 256);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish in time");
   end

   initial begin
      int p0, v0;
      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_pass", pass_cnt, 0);
      chk("reset_ffv", ff_valid, 0);
      rst_n = 1'b1;

      // Constant minimum candidate, with fixed figures as well as the model.
      start_run(2'd0, "s1");
      finish_run("s1");
      chk("s1_pass_139", pass_cnt, 139);
      chk("s1_vac_117", vac_cnt, 117);
      chk("s1_fail_0", fail_cnt, 0);
      chk("s1_busy_2384", busy_total - busy_base, 2384);

      // Constant zero candidate.
      start_run(2'd1, "s2");
      finish_run("s2");
      chk("s2_pass_112", pass_cnt, 112);
      chk("s2_fail_27", fail_cnt, 27);
      chk("s2_ff", {ff_valid, ff_s, ff_t, ff_x}, {1'b1, 12'd0});

      // Correct Skolem function.
      start_run(2'd2, "s3");
      finish_run("s3");
      chk("s3_fail_0", fail_cnt, 0);
      chk("s3_vac_117", vac_cnt, 117);

      // Abort mid-sweep with reset, then a clean rerun.
      mode_r = 2'd0;
      pulse_start();
      wait_k(40, "s4_k40");
      #2 rst_n = 1'b0;
      #1;
      chk("s4_rst_pass", pass_cnt, 0);
      chk("s4_rst_busy", busy, 0);
      chk("s4_rst_ffv", ff_valid, 0);
      chk("s4_rst_k", {cand_t, cand_s}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      start_run(2'd0, "s4_rerun");
      finish_run("s4_rerun");

      // Start while busy is ignored; a start after done restarts.
      start_run(2'd0, "s5");
      repeat (100) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_run("s5");
      chk("s5_done_level", done, 1);
      start_run(2'd0, "s5_again");

      // Boundary pairs inside this run: k=15 (s=15,t=0) and k=255 (s=15,t=-1).
      wait_k(15, "s6_k15");
      p0 = int'(pass_cnt);
      v0 = int'(vac_cnt);
      wait_k(16, "s6_k16");
      chk("s6_k15_pass", int'(pass_cnt) - p0, 1);
      chk("s6_k15_vac", int'(vac_cnt) - v0, 0);
      wait_k(255, "s6_k255");
      p0 = int'(pass_cnt);
      v0 = int'(vac_cnt);
      finish_run("s5_again");
      chk("s6_k255_vac", int'(vac_cnt) - v0, 1);
      chk("s6_k255_pass", int'(pass_cnt) - p0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/skolem_inv_sweep_checker.md
Name: skolem_inv_sweep_checker

Overview:
- Sequential verification stage directly downstream of a combinational W-bit Skolem function for the invertibility condition "exists x: bvashr(x, s) <s t".
- Sweeps every (s, t) pair and drives them into the Skolem function, then samples its candidate x.
- Checks each candidate against the predicate. If a candidate fails, brute-forces all x to decide whether a witness exists.
- Counts PASS, VACUOUS and FAIL outcomes and captures the first failing vector, so a generated Skolem netlist can be signed off in hardware or simulation.

Parameters:
- W, 4, bit width of s, t and x (the sweep covers 2^(2W) pairs).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a full sweep; ignored while busy.
- cand_s  out  W  shift operand s driven to the Skolem function.
- cand_t  out  W  bound t driven to the Skolem function.
- cand_x  in  W  candidate x returned combinationally by the Skolem function.
- busy  out  1  high from the cycle after an accepted start until done rises.
- done  out  1  level; high after a sweep completes, cleared by the next accepted start.
- pass_cnt  out  2W+1  number of pairs where the candidate satisfied the predicate.
- vac_cnt  out  2W+1  number of pairs where no witness x exists.
- fail_cnt  out  2W+1  number of pairs where a witness exists but the candidate failed.
- ff_valid  out  1  a failing pair has been captured.
- ff_s, ff_t, ff_x  out  W each  s, t and candidate x of the first failing pair.

Behaviour:
- Reset: asynchronous, active-low. All outputs and counters go to 0 and the FSM goes to IDLE. Asserting reset mid-sweep aborts the sweep with no partial results retained.
- Predicate P(x, s, t):
  - Arithmetic right shift of x by unsigned s, with the sign bit filling vacated positions. For s >= W the result is all sign bits.
  - The result is compared to t as W-bit two's complement, strictly less-than.
- Scan order:
  - Index k = {t, s}, k from 0 to 2^(2W)-1, unsigned.
  - s is the inner (least significant) field; t is the outer field.
- FSM states IDLE, DRIVE, CHECK, SWEEP, DONE:
  - IDLE: when start is high, clear counters, ff_* and done; k=0; go to DRIVE.
  - DRIVE (1 cycle): cand_s/cand_t are registered from k and held stable until the next DRIVE.
  - CHECK (1 cycle): sample cand_x and evaluate P(cand_x, s, t).
    - True: pass_cnt++, then advance.
    - False: load xs=0 and go to SWEEP.
  - SWEEP (1 value per cycle, xs ascending unsigned):
    - If P(xs, s, t) is true: fail_cnt++. If ff_valid is 0, capture s, t and the sampled cand_x and set ff_valid. Then advance.
    - If xs reaches 2^W-1 with P false: vac_cnt++, then advance.
    - The sweep is therefore 1 to 2^W cycles.
  - Advance: if k = 2^(2W)-1 go to DONE, else k++ and go to DRIVE.
  - DONE: done=1, busy=0, return to IDLE the same cycle. Counters and ff_* hold until the next start.
- Invariant at done: pass_cnt + vac_cnt + fail_cnt = 2^(2W). The counters are sized so this sum never wraps.
- Only the first FAIL is captured; later FAILs increment fail_cnt only.
- start while busy has no effect. start in the cycle done rises is accepted on the following cycle only.
- cand_x is never sampled in DRIVE, which gives the Skolem function one full cycle of settling.

Test Plan:
1. cand_x tied to 4'b1000, W=4:
   - pulse start -> done; pass_cnt=139, vac_cnt=117, fail_cnt=0, ff_valid=0.
   - busy high for exactly 2*139 + 18*117 = 2384 cycles.
2. cand_x tied to 4'b0000:
   - -> pass_cnt=112, vac_cnt=117, fail_cnt=27, ff_valid=1, ff_s=0, ff_t=0, ff_x=0.
3. cand_x driven by the reference-correct Skolem netlist:
   - -> fail_cnt=0, and pass_cnt + vac_cnt = 256 with vac_cnt=117.
4. Assert rst_n low mid-sweep at k=40:
   - -> all counters, ff_* and busy go to 0 immediately (asynchronously).
   - A subsequent start gives results identical to a clean run.
5. Pulse start again while busy:
   - -> ignored; final counts are unchanged vs scenario 1.
   - A second start after done clears done and the counters on the next edge and reruns.
6. Boundary pairs, cand_x=4'b1000:
   - s=15 with t=4'b1111 -> counted VACUOUS (-1 <s -1 is false).
   - s=15 with t=0 -> counted PASS.
